// File: rtl/matmul.sv
// APB-slave signed integer matrix-multiply engine: C = A(NxK) * B(KxM), one MAC per cycle,
// results land in a multi-target scratchpad with optional accumulation onto a previous result.
module matmul #(
   parameter int DATA_WIDTH  = 8,
   parameter int BUS_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int SP_NTARGETS = 4,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [MAX_DIM-1:0]    pstrb_i,
   input  logic [BUS_WIDTH-1:0]  pwdata_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [BUS_WIDTH-1:0]  prdata_o,
   output logic                  busy_o
);

   localparam int DIM_W    = $clog2(MAX_DIM);
   localparam int T_W      = $clog2(SP_NTARGETS);
   localparam int IDX_W    = ADDR_WIDTH - 5;
   localparam int NFLAGS   = MAX_DIM * MAX_DIM;
   localparam int SP_IDX_W = T_W + 2 * DIM_W;
   localparam int SP_DEPTH = SP_NTARGETS * NFLAGS;
   localparam int PW       = 2 * DATA_WIDTH;

   localparam logic [4:0] REG_CTRL  = 5'h00;
   localparam logic [4:0] REG_OPA   = 5'h04;
   localparam logic [4:0] REG_OPB   = 5'h08;
   localparam logic [4:0] REG_FLAGS = 5'h0C;
   localparam logic [4:0] REG_SP    = 5'h10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                             r_state;
   logic                                   r_start;
   logic                                   r_mode;
   logic [T_W-1:0]                         r_wt;
   logic [T_W-1:0]                         r_rt;
   logic [DIM_W-1:0]                       r_n1;
   logic [DIM_W-1:0]                       r_k1;
   logic [DIM_W-1:0]                       r_m1;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]     r_a [MAX_DIM];
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]     r_b [MAX_DIM];
   logic [BUS_WIDTH-1:0]                   r_sp [SP_DEPTH];
   logic [NFLAGS-1:0]                      r_flags;
   logic [DIM_W-1:0]                       r_i;
   logic [DIM_W-1:0]                       r_j;
   logic [DIM_W-1:0]                       r_k;
   logic [BUS_WIDTH-1:0]                   r_acc;
   logic                                   r_ovf;

   logic                   w_access;
   logic                   w_busy;
   logic [4:0]             w_region;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_idx_zero;
   logic                   w_idx_op_ok;
   logic                   w_idx_sp_ok;
   logic [DIM_W-1:0]       w_op_row;
   logic [SP_IDX_W-1:0]    w_sp_idx;
   logic                   w_err;
   logic                   w_wr_ok;
   logic                   w_start;
   logic [BUS_WIDTH-1:0]   w_ctrl;
   logic [BUS_WIDTH-1:0]   w_rdata;
   logic signed [DATA_WIDTH-1:0] w_a_el;
   logic signed [DATA_WIDTH-1:0] w_b_el;
   logic signed [PW-1:0]   w_prod;
   logic [BUS_WIDTH-1:0]   w_prod_ext;
   logic [BUS_WIDTH-1:0]   w_acc_in;
   logic [BUS_WIDTH-1:0]   w_sum;
   logic                   w_add_ovf;
   logic                   w_ovf_any;
   logic                   w_last_k;
   logic                   w_last_j;
   logic                   w_last_i;
   logic                   w_commit;

   assign w_access    = psel_i & penable_i;
   assign w_busy      = (r_state != ST_IDLE);
   assign w_region    = paddr_i[4:0];
   assign w_idx       = paddr_i[ADDR_WIDTH-1:5];
   assign w_idx_zero  = (w_idx == '0);
   assign w_idx_op_ok = (w_idx[IDX_W-1:DIM_W] == '0);
   assign w_idx_sp_ok = (w_idx[IDX_W-1:SP_IDX_W] == '0);
   assign w_op_row    = w_idx[DIM_W-1:0];
   assign w_sp_idx    = w_idx[SP_IDX_W-1:0];

   // While busy only CONTROL/FLAGS reads get through, so operands and SP are stable for the engine.
   always_comb begin
      // NOTE: default first so every path assigns w_err and no latch is inferred.
      w_err = 1'b1;
      case (w_region)
         REG_CTRL:         w_err = !w_idx_zero || (w_busy && pwrite_i);
         REG_OPA, REG_OPB: w_err = !w_idx_op_ok || w_busy;
         REG_FLAGS:        w_err = !w_idx_zero || pwrite_i;
         REG_SP:           w_err = !w_idx_sp_ok || pwrite_i || w_busy;
         default:          w_err = 1'b1;
      endcase
   end

   assign w_wr_ok = w_access & pwrite_i & ~w_err;
   assign w_start = w_wr_ok && (w_region == REG_CTRL) && pwdata_i[0];

   always_comb begin
      w_ctrl                  = '0;
      w_ctrl[0]               = r_start;
      w_ctrl[1]               = r_mode;
      w_ctrl[2 +: T_W]        = r_wt;
      w_ctrl[4 +: T_W]        = r_rt;
      w_ctrl[8 +: DIM_W]      = r_n1;
      w_ctrl[10 +: DIM_W]     = r_k1;
      w_ctrl[12 +: DIM_W]     = r_m1;
   end

   always_comb begin
      w_rdata = '0;
      case (w_region)
         REG_CTRL:  w_rdata = w_ctrl;
         REG_OPA:   w_rdata = r_a[w_op_row];
         REG_OPB:   w_rdata = r_b[w_op_row];
         REG_FLAGS: w_rdata = {{(BUS_WIDTH-NFLAGS){1'b0}}, r_flags};
         REG_SP:    w_rdata = r_sp[w_sp_idx];
         default:   w_rdata = '0;
      endcase
   end

   assign pready_o  = w_access;
   assign pslverr_o = w_access & w_err;
   assign prdata_o  = (w_access && !pwrite_i && !w_err) ? w_rdata : '0;
   assign busy_o    = w_busy;

   // Datapath: the element accumulator is seeded on k==0, either from SP[rt] or from zero.
   assign w_a_el     = r_a[r_i][r_k];
   assign w_b_el     = r_b[r_k][r_j];
   assign w_prod     = w_a_el * w_b_el;
   assign w_prod_ext = {{(BUS_WIDTH-PW){w_prod[PW-1]}}, w_prod};
   assign w_acc_in   = (r_k != '0) ? r_acc : (r_mode ? r_sp[{r_rt, r_i, r_j}] : '0);
   assign w_sum      = w_acc_in + w_prod_ext;
   assign w_add_ovf  = (w_acc_in[BUS_WIDTH-1] == w_prod_ext[BUS_WIDTH-1]) &&
                       (w_sum[BUS_WIDTH-1] != w_acc_in[BUS_WIDTH-1]);
   assign w_ovf_any  = ((r_k != '0) && r_ovf) || w_add_ovf;
   assign w_last_k   = (r_k == r_k1);
   assign w_last_j   = (r_j == r_m1);
   assign w_last_i   = (r_i == r_n1);
   assign w_commit   = (r_state == ST_RUN) && w_last_k;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_start <= 1'b0;
         r_mode  <= 1'b0;
         r_wt    <= '0;
         r_rt    <= '0;
         r_n1    <= '0;
         r_k1    <= '0;
         r_m1    <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_wr_ok && (w_region == REG_CTRL)) begin
            r_start <= pwdata_i[0];
            r_mode  <= pwdata_i[1];
            r_wt    <= pwdata_i[2 +: T_W];
            r_rt    <= pwdata_i[4 +: T_W];
            r_n1    <= pwdata_i[8 +: DIM_W];
            r_k1    <= pwdata_i[10 +: DIM_W];
            r_m1    <= pwdata_i[12 +: DIM_W];
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state <= ST_RUN;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_k     <= '0;
               end
            end
            ST_RUN: begin
               r_acc <= w_sum;
               r_ovf <= w_ovf_any;
               if (!w_last_k) begin
                  r_k <= r_k + 1'b1;
               end else begin
                  r_k <= '0;
                  if (!w_last_j) begin
                     r_j <= r_j + 1'b1;
                  end else begin
                     r_j <= '0;
                     if (!w_last_i) r_i <= r_i + 1'b1;
                     else           r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_start <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < MAX_DIM; r++) begin
            r_a[r] <= '0;
            r_b[r] <= '0;
         end
      end else if (w_wr_ok) begin
         for (int l = 0; l < MAX_DIM; l++) begin
            if (pstrb_i[l] && (w_region == REG_OPA)) r_a[w_op_row][l] <= pwdata_i[l*DATA_WIDTH +: DATA_WIDTH];
            if (pstrb_i[l] && (w_region == REG_OPB)) r_b[w_op_row][l] <= pwdata_i[l*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_flags <= '0;
      end else if (w_start) begin
         r_flags <= '0;
      end else if (w_commit) begin
         r_flags[{r_i, r_j}] <= w_ovf_any;
      end
   end

   // NOTE: the scratchpad must read as zero after reset, so it is built from resettable flops, not RAM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int n = 0; n < SP_DEPTH; n++) r_sp[n] <= '0;
      end else if (w_commit) begin
         r_sp[{r_wt, r_i, r_j}] <= w_sum;
      end
   end

endmodule

// File: tb/tb_matmul.sv
// Self-checking bench for matmul: table-driven APB vectors through a scoreboard queue,
// plus hand-written sequences for busy timing, busy protection, accumulation and reset abort.
module tb_matmul;

   localparam int DW = 8;
   localparam int BW = 32;
   localparam int AW = 16;
   localparam int NT = 4;
   localparam int MD = BW / DW;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          psel_i;
   logic          penable_i;
   logic          pwrite_i;
   logic [MD-1:0] pstrb_i;
   logic [BW-1:0] pwdata_i;
   logic [AW-1:0] paddr_i;
   logic          pready_o;
   logic          pslverr_o;
   logic [BW-1:0] prdata_o;
   logic          busy_o;

   matmul #(
      .DATA_WIDTH (DW),
      .BUS_WIDTH  (BW),
      .ADDR_WIDTH (AW),
      .SP_NTARGETS(NT)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .psel_i   (psel_i),
      .penable_i(penable_i),
      .pwrite_i (pwrite_i),
      .pstrb_i  (pstrb_i),
      .pwdata_i (pwdata_i),
      .paddr_i  (paddr_i),
      .pready_o (pready_o),
      .pslverr_o(pslverr_o),
      .prdata_o (prdata_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string         name;
      logic [AW-1:0] addr;
      logic          wr;
      logic [BW-1:0] wdata;
      logic [MD-1:0] strb;
      logic [BW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   localparam logic [AW-1:0] A_CTRL  = 16'h0000;
   localparam logic [AW-1:0] A_FLAGS = 16'h000C;

   function automatic logic [AW-1:0] a_opa(int row);
      return AW'((row << 5) | 4);
   endfunction

   function automatic logic [AW-1:0] a_opb(int row);
      return AW'((row << 5) | 8);
   endfunction

   function automatic logic [AW-1:0] a_sp(int idx);
      return AW'((idx << 5) | 16);
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   function automatic void add_rd(string name, logic [AW-1:0] addr, logic [BW-1:0] exp, logic err);
      vecs.push_back('{name, addr, 1'b0, '0, '0, exp, err});
   endfunction

   function automatic void add_wr(string name, logic [AW-1:0] addr, logic [BW-1:0] data,
                                  logic [MD-1:0] strb, logic err);
      vecs.push_back('{name, addr, 1'b1, data, strb, '0, err});
   endfunction

   // One APB transfer: setup on a falling edge, access on the next, sample 1ns into access.
   task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wdata,
                           input logic [MD-1:0] strb, output logic [BW-1:0] rdata,
                           output logic ready, output logic err);
      @(negedge clk_i);
      psel_i    = 1'b1;
      penable_i = 1'b0;
      paddr_i   = addr;
      pwrite_i  = wr;
      pwdata_i  = wdata;
      pstrb_i   = strb;
      @(negedge clk_i);
      penable_i = 1'b1;
      #1;
      rdata = prdata_o;
      ready = pready_o;
      err   = pslverr_o;
      @(posedge clk_i);
      #1;
      psel_i    = 1'b0;
      penable_i = 1'b0;
      pwrite_i  = 1'b0;
   endtask

   task automatic run_vecs();
      vec_t          v;
      vec_t          e;
      logic [BW-1:0] rd;
      logic          rdy;
      logic          er;
      for (int n = 0; n < vecs.size(); n++) begin
         v = vecs[n];
         sb.push_back(v);
         apb_xfer(v.addr, v.wr, v.wdata, v.strb, rd, rdy, er);
         e = sb.pop_front();
         check({e.name, "/resp"}, {30'b0, rdy, er}, {30'b0, 1'b1, e.exp_err});
         if (!e.wr && !e.exp_err) check({e.name, "/data"}, rd, e.exp_rdata);
      end
      vecs.delete();
   endtask

   task automatic start_op(input string name, input logic [BW-1:0] ctrl);
      add_wr(name, A_CTRL, ctrl, '1, 1'b0);
      run_vecs();
   endtask

   // Counts busy cycles from the edge that accepted the start; bounded so a stuck engine still ends.
   task automatic wait_idle(output int cnt);
      cnt = 0;
      @(negedge clk_i);
      while (busy_o && cnt < 200) begin
         cnt++;
         @(negedge clk_i);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      int            cnt;
      logic [BW-1:0] rd;
      logic          rdy;
      logic          er;

      rst_ni    = 1'b0;
      psel_i    = 1'b0;
      penable_i = 1'b0;
      pwrite_i  = 1'b0;
      pstrb_i   = '0;
      pwdata_i  = '0;
      paddr_i   = '0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("reset/busy", {31'b0, busy_o}, '0);

      // Reset values, decode errors, operand loads with garbage outside the active dimensions.
      add_rd("rst/ctrl",  A_CTRL,   '0, 1'b0);
      add_rd("rst/opa0",  a_opa(0), '0, 1'b0);
      add_rd("rst/opb3",  a_opb(3), '0, 1'b0);
      add_rd("rst/flags", A_FLAGS,  '0, 1'b0);
      add_rd("rst/sp0",   a_sp(0),  '0, 1'b0);
      add_rd("rst/sp63",  a_sp(63), '0, 1'b0);
      add_rd("err/reg14", 16'h0014, '0, 1'b1);
      add_rd("err/opa4",  a_opa(4), '0, 1'b1);
      add_rd("err/sp64",  a_sp(64), '0, 1'b1);
      add_rd("err/ctrl1", 16'h0020, '0, 1'b1);
      add_wr("err/wflags", A_FLAGS, 32'hFFFF_FFFF, '1, 1'b1);
      add_wr("err/wsp",    a_sp(0), 32'h1234_5678, '1, 1'b1);
      add_wr("ld/a0", a_opa(0), 32'h7F03_0201, '1, 1'b0);
      add_wr("ld/a1", a_opa(1), 32'h0006_0504, '1, 1'b0);
      add_wr("ld/b0", a_opb(0), 32'h5566_0807, '1, 1'b0);
      add_wr("ld/b1", a_opb(1), 32'h0000_0A09, '1, 1'b0);
      add_wr("ld/b2", a_opb(2), 32'h0000_0C0B, '1, 1'b0);
      add_wr("ld/a3", a_opa(3), 32'hAABB_CCDD, 4'b0101, 1'b0);
      add_rd("rb/a3strb", a_opa(3), 32'h00BB_00DD, 1'b0);
      add_rd("rb/a0",     a_opa(0), 32'h7F03_0201, 1'b0);
      add_rd("rb/b2",     a_opb(2), 32'h0000_0C0B, 1'b0);
      add_rd("rb/flags",  A_FLAGS,  '0, 1'b0);
      add_rd("rb/sp0",    a_sp(0),  '0, 1'b0);
      run_vecs();

      // Basic 2x3 * 3x2 into target 0.
      start_op("basic/start", 32'h0000_1901);
      wait_idle(cnt);
      check("basic/busy_cycles", cnt, 32'd13);
      add_rd("basic/sp0",   a_sp(0), 32'd58,  1'b0);
      add_rd("basic/sp1",   a_sp(1), 32'd64,  1'b0);
      add_rd("basic/sp4",   a_sp(4), 32'd139, 1'b0);
      add_rd("basic/sp5",   a_sp(5), 32'd154, 1'b0);
      add_rd("basic/sp2",   a_sp(2), '0, 1'b0);
      add_rd("basic/sp8",   a_sp(8), '0, 1'b0);
      add_rd("basic/flags", A_FLAGS, '0, 1'b0);
      add_rd("basic/ctrl",  A_CTRL,  32'h0000_1900, 1'b0);
      run_vecs();

      // Accumulate SP[0] into SP[1], probing busy protection mid-computation.
      start_op("acc/start", 32'h0000_1907);
      apb_xfer(a_opa(0), 1'b1, 32'hFFFF_FFFF, '1, rd, rdy, er);
      check("busy/wr_opa_err", {31'b0, er}, 32'd1);
      apb_xfer(A_CTRL, 1'b0, '0, '0, rd, rdy, er);
      check("busy/rd_ctrl_err", {31'b0, er}, '0);
      check("busy/rd_ctrl", rd, 32'h0000_1907);
      apb_xfer(A_FLAGS, 1'b0, '0, '0, rd, rdy, er);
      check("busy/rd_flags_err", {31'b0, er}, '0);
      check("busy/rd_flags", rd, '0);
      apb_xfer(a_sp(0), 1'b0, '0, '0, rd, rdy, er);
      check("busy/rd_sp_err", {31'b0, er}, 32'd1);
      #1;
      check("busy/still_busy", {31'b0, busy_o}, 32'd1);
      wait_idle(cnt);
      check("acc/done", {31'b0, busy_o}, '0);
      add_rd("acc/a0_kept", a_opa(0), 32'h7F03_0201, 1'b0);
      add_rd("acc/sp16", a_sp(16), 32'd116, 1'b0);
      add_rd("acc/sp17", a_sp(17), 32'd128, 1'b0);
      add_rd("acc/sp20", a_sp(20), 32'd278, 1'b0);
      add_rd("acc/sp21", a_sp(21), 32'd308, 1'b0);
      add_rd("acc/sp0",  a_sp(0),  32'd58,  1'b0);
      add_rd("acc/sp5",  a_sp(5),  32'd154, 1'b0);
      add_rd("acc/ctrl", A_CTRL,   32'h0000_1906, 1'b0);
      run_vecs();

      // Signed extremes: -128 * -128, 1x1x1 into target 2, then accumulate in place (wt == rt).
      add_wr("sgn/a0", a_opa(0), 32'h0000_0080, 4'b0001, 1'b0);
      add_wr("sgn/b0", a_opb(0), 32'h0000_0080, 4'b0001, 1'b0);
      run_vecs();
      start_op("sgn/start", 32'h0000_0009);
      wait_idle(cnt);
      check("sgn/busy_cycles", cnt, 32'd2);
      add_rd("sgn/sp32", a_sp(32), 32'h0000_4000, 1'b0);
      add_rd("sgn/sp33", a_sp(33), '0, 1'b0);
      run_vecs();
      start_op("inpl/start", 32'h0000_002B);
      wait_idle(cnt);
      check("inpl/busy_cycles", cnt, 32'd2);
      add_rd("inpl/sp32",  a_sp(32), 32'h0000_8000, 1'b0);
      add_rd("inpl/sp16",  a_sp(16), 32'd116, 1'b0);
      add_rd("inpl/flags", A_FLAGS,  '0, 1'b0);
      run_vecs();

      // Abort: reset mid-computation clears busy at once and wipes the scratchpad.
      start_op("abort/start", 32'h0000_190D);
      repeat (4) @(negedge clk_i);
      check("abort/busy_before", {31'b0, busy_o}, 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("abort/busy_after", {31'b0, busy_o}, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int n = 0; n < NT * MD * MD; n++) add_rd($sformatf("abort/sp%0d", n), a_sp(n), '0, 1'b0);
      add_rd("abort/ctrl", A_CTRL,   '0, 1'b0);
      add_rd("abort/opa0", a_opa(0), '0, 1'b0);
      run_vecs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/matmul.md
Name: matmul

Overview:
- APB-slave signed integer matrix-multiply accelerator. Computes C = A(N×K) · B(K×M), with N, K, M ≤ MAX_DIM = BUS_WIDTH/DATA_WIDTH.
- Results are written to a multi-target scratchpad (SP), with optional accumulation onto a previous result.
- Sits on the system APB bus. A host loads operands, starts the engine, polls busy_o and reads results and flags.

Parameters:
- DATA_WIDTH, 8, operand element width, signed two's complement.
- BUS_WIDTH, 32, APB data width and width of each result element.
- ADDR_WIDTH, 16, APB address width.
- SP_NTARGETS, 4, number of scratchpad result matrices. Power of 2.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- pstrb_i  in  MAX_DIM  byte-lane write strobes.
- pwdata_i  in  BUS_WIDTH  write data.
- paddr_i  in  ADDR_WIDTH  byte address.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error, valid while pready_o=1.
- prdata_o  out  BUS_WIDTH  read data, valid while pready_o=1.
- busy_o  out  1  engine computing.

Behaviour:
- Reset: all registers, operand memories, SP, flags and outputs go to 0. Reset during a computation aborts it immediately.
- Address decode:
  - paddr_i[4:0] selects the region: 0x00 CONTROL, 0x04 OPERAND_A, 0x08 OPERAND_B, 0x0C FLAGS, 0x10 SP.
  - idx = paddr_i[ADDR_WIDTH-1:5].
  - Any other region, or idx out of range, returns pslverr_o=1 with no side effect.
- APB timing:
  - Zero wait states: pready_o = psel_i & penable_i.
  - Writes commit at the access-phase clock edge.
  - prdata_o is combinational from storage during the access phase and 0 otherwise.
- CONTROL (R/W) bits:
  - [0] start.
  - [1] mode: accumulate.
  - [3:2] write target (wt).
  - [5:4] read target (rt).
  - [9:8] N-1, [11:10] K-1, [13:12] M-1.
  - Other bits read 0.
- OPERAND_A (R/W):
  - idx = row i, 0..MAX_DIM-1.
  - Byte lane k holds A[i][k].
  - pstrb_i masks lane writes.
- OPERAND_B (R/W): idx = row k; byte lane j holds B[k][j]; pstrb_i masks lanes.
- FLAGS (RO): bit i*MAX_DIM+j = signed overflow of C[i][j] in the last operation.
- SP (RO):
  - idx = t*MAX_DIM² + i*MAX_DIM + j.
  - Returns a BUS_WIDTH signed element.
- Writes to FLAGS or SP return pslverr_o=1 and are ignored.
- While busy_o=1: every access except a read of CONTROL or FLAGS returns pslverr_o=1 with no side effect.
- Start:
  - A CONTROL write with bit0=1 while idle is accepted.
  - busy_o rises at the next edge and flags clear.
  - Start bit reads 1 until completion, then self-clears.
- Engine:
  - One MAC per cycle.
  - Output elements processed in row-major order (i, then j); k runs 0..K-1 per element.
  - Element accumulator is initialised to SP[rt][i][j] when mode=1, else 0.
  - acc += sext(A[i][k]) · sext(B[k][j]), at BUS_WIDTH width.
  - On the last k, C[i][j] is written to SP[wt][i][j] and its overflow flag is set if any add overflowed the signed BUS_WIDTH range. The result wraps.
  - wt = rt with mode=1 is legal: each element reads the old value before overwriting it.
- busy_o is high for exactly N·M·K + 1 cycles (the final cycle commits), then falls.
- SP entries outside N×M of target wt are unchanged.
- Operand elements outside the active dimensions are ignored.

Test Plan:
- Reset: after reset release, every region reads 0 and busy_o=0. Read paddr=0x14 -> pslverr_o=1.
- Basic multiply:
  - Setup: A rows {1,2,3},{4,5,6}; B rows {7,8},{9,10},{11,12}; N-1=1, K-1=2, M-1=1, wt=0, start.
  - Response: busy_o high 13 cycles. SP[0] reads 58, 64, 139, 154 at idx 0, 1, 4, 5. FLAGS = 0.
- Signed operands: A = {-128}, B = {-128}, 1×1×1 -> C = 16384 (0x00004000). Lane bytes 0x80.
- Accumulate: repeat the basic multiply with mode=1, rt=0, wt=1 -> SP[1] = 116, 128, 278, 308. SP[0] unchanged.
- Busy protection: during the computation, write OPERAND_A -> pslverr_o=1 and data unchanged. Read CONTROL -> bit0=1, pslverr_o=0.
- Abort: assert rst_ni low mid-computation -> busy_o=0 immediately and SP all zero.
